// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared fetch-controller state encoding and address constants
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Instructions are word aligned; these low address bits are forced to zero on redirects.
    localparam logic [1:0] ALIGN_LSBS = 2'b11;

endpackage

// File: rtl/pc_fetch_ctrl_next_pc_sel.sv
// next_pc_sel: next-PC priority mux (jump > branch > sequential) with target alignment
module next_pc_sel
    import cpu_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] pc_plus4_i,
    input  logic                  br_taken_i,
    input  logic [ADDR_WIDTH-1:0] br_target_i,
    input  logic                  jmp_valid_i,
    input  logic [ADDR_WIDTH-1:0] jmp_target_i,
    output logic                  redir_o,
    output logic [ADDR_WIDTH-1:0] next_pc_o
);

    localparam logic [ADDR_WIDTH-1:0] MASK = ~ADDR_WIDTH'(ALIGN_LSBS);

    assign redir_o   = jmp_valid_i | br_taken_i;
    assign next_pc_o = jmp_valid_i ? (jmp_target_i & MASK) :
                       br_taken_i  ? (br_target_i & MASK)  : pc_plus4_i;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter, instruction-memory read handshake and decode handoff
module pc_fetch_ctrl
    import cpu_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    INSTR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [ADDR_WIDTH-1:0]  pc_addr,
    input  logic [ADDR_WIDTH-1:0]  pc_plus4,
    input  logic                   br_taken,
    input  logic [ADDR_WIDTH-1:0]  br_target,
    input  logic                   jmp_valid,
    input  logic [ADDR_WIDTH-1:0]  jmp_target,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    input  logic                   instr_ready
);

    fetch_state_e           state_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [ADDR_WIDTH-1:0]  pc_d;
    logic                   drop_q;
    logic                   imem_req_q;
    logic                   instr_valid_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [ADDR_WIDTH-1:0]  instr_pc_q;
    logic                   redir;

    next_pc_sel #(.ADDR_WIDTH(ADDR_WIDTH)) u_next_pc_sel (
        .pc_plus4_i   (pc_plus4),
        .br_taken_i   (br_taken),
        .br_target_i  (br_target),
        .jmp_valid_i  (jmp_valid),
        .jmp_target_i (jmp_target),
        .redir_o      (redir),
        .next_pc_o    (pc_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_VECTOR;
            drop_q        <= 1'b0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q    <= S_REQ;
                    imem_req_q <= 1'b1;
                end
                S_REQ: begin
                    if (redir)
                        pc_q <= pc_d;
                    // A redirect in the accept cycle makes the read stale: mark it for discard.
                    if (imem_ready) begin
                        state_q    <= S_WAIT;
                        drop_q     <= redir;
                        imem_req_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (redir)
                        pc_q <= pc_d;
                    if (imem_rvalid && !(drop_q || redir)) begin
                        instr_q       <= imem_rdata;
                        instr_pc_q    <= pc_q;
                        state_q       <= S_HOLD;
                        instr_valid_q <= 1'b1;
                    end else if (imem_rvalid) begin
                        drop_q     <= 1'b0;
                        state_q    <= S_REQ;
                        imem_req_q <= 1'b1;
                    end else if (redir) begin
                        drop_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // pc_d already prefers the redirect target over pc_plus4.
                    if (redir || instr_ready) begin
                        pc_q          <= pc_d;
                        state_q       <= S_REQ;
                        instr_valid_q <= 1'b0;
                        imem_req_q    <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pc_addr     = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = imem_req_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule
